muldiv_sequencer: RTL and testbench

//  Iterative signed multiply/divide engine and its sequencer, started by control_unit for MULT, DIV and DIVM.
//  It owns the shift/add datapath, the iteration counter and the HI/LO write strobes.

---
 rtl/muldiv_if.sv | 19 +
 rtl/muldiv_sequencer.sv | 112 +++++++++++
 tb/tb_muldiv_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: start/busy/done handshake and HI/LO result bus between control_unit and the muldiv engine
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             hi_w;
  logic             lo_w;
  logic             div_zero;
  modport master (output start, op, a_in, b_in, abort,
                  input  busy, done, hi_out, lo_out, hi_w, lo_w, div_zero);
  modport slave  (input  start, op, a_in, b_in, abort,
                  output busy, done, hi_out, lo_out, hi_w, lo_w, div_zero);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative signed Booth multiply / restoring divide with start/busy/done sequencing
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic     clk,
  input logic     reset_in,
  muldiv_if.slave bus
);
  localparam int W = WIDTH;
  typedef enum logic [2:0] {IDLE, RUN, FIX, DONE, ZERO} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W:0]       hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     res_hi_q, res_hi_d;
  logic [W-1:0]     res_lo_q, res_lo_d;
  logic             qm1_q, qm1_d;
  logic             mul_q, mul_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [W-1:0]     a_abs, b_abs;
  logic [W:0]       sum, sh;
  logic             ge;
  // Booth add/sub on the sign-extended high half; restoring trial subtract on the shifted remainder
  always_comb begin
    a_abs = bus.a_in[W-1] ? -bus.a_in : bus.a_in;
    b_abs = bus.b_in[W-1] ? -bus.b_in : bus.b_in;
    sum   = (lo_q[0] & ~qm1_q) ? hi_q - {b_q[W-1], b_q} :
            (~lo_q[0] & qm1_q) ? hi_q + {b_q[W-1], b_q} : hi_q;
    sh    = {hi_q[W-1:0], lo_q[W-1]};
    ge    = sh >= {1'b0, b_q};
  end
  // Next-state and datapath update; result registers load only at the end of FIX
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    qm1_d    = qm1_q;
    mul_d    = mul_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    case (state_q)
      IDLE: if (bus.start && bus.op != 2'b11) begin
        mul_d   = bus.op == 2'b00;
        sa_d    = bus.a_in[W-1];
        sb_d    = bus.b_in[W-1];
        hi_d    = '0;
        qm1_d   = 1'b0;
        cnt_d   = '0;
        lo_d    = mul_d ? bus.a_in : a_abs;
        b_d     = mul_d ? bus.b_in : b_abs;
        state_d = (!mul_d && bus.b_in == '0) ? ZERO : RUN;
      end
      RUN: if (bus.abort) state_d = IDLE;
      else begin
        cnt_d   = cnt_q + CNT_W'(1);
        hi_d    = mul_q ? {sum[W], sum[W:1]} : (ge ? sh - {1'b0, b_q} : sh);
        lo_d    = mul_q ? {sum[0], lo_q[W-1:1]} : {lo_q[W-2:0], ge};
        qm1_d   = lo_q[0];
        state_d = (cnt_q == CNT_W'(W-1)) ? FIX : RUN;
      end
      FIX: if (bus.abort) state_d = IDLE;
      else begin
        res_lo_d = (!mul_q && (sa_q ^ sb_q)) ? -lo_q : lo_q;
        res_hi_d = (!mul_q && sa_q) ? -hi_q[W-1:0] : hi_q[W-1:0];
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      qm1_q    <= 1'b0;
      mul_q    <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      qm1_q    <= qm1_d;
      mul_q    <= mul_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end
  assign bus.busy     = state_q == RUN || state_q == FIX || state_q == DONE;
  assign bus.hi_w     = state_q == DONE && !bus.abort;
  assign bus.lo_w     = bus.hi_w;
  assign bus.div_zero = state_q == ZERO;
  assign bus.done     = bus.hi_w || bus.div_zero;
  assign bus.hi_out   = res_hi_q;
  assign bus.lo_out   = res_lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed checks of muldiv_sequencer results, latency, abort and reset
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic reset_in = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n;
  int   cnt;
  muldiv_if bus ();
  muldiv_sequencer dut (.clk(clk), .reset_in(reset_in), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a_in  = a;
    bus.b_in  = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic wait_done(output int k);
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      if (bus.done) break;
      k++;
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.op    = 2'b00;
    bus.a_in  = '0;
    bus.b_in  = '0;
    #2;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi_out), 64'd0);
    check("rst_lo", 64'(bus.lo_out), 64'd0);
    #10 reset_in = 1'b1;
    issue(2'b00, 32'd7, 32'hFFFF_FFFD);
    wait_done(n);
    check("mul_lat", 64'(n), 64'd33);
    check("mul_hi", 64'(bus.hi_out), 64'hFFFF_FFFF);
    check("mul_lo", 64'(bus.lo_out), 64'hFFFF_FFEB);
    check("mul_hiw", 64'(bus.hi_w), 64'd1);
    check("mul_low", 64'(bus.lo_w), 64'd1);
    check("mul_dz", 64'(bus.div_zero), 64'd0);
    check("mul_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    check("mul_hiw_end", 64'(bus.hi_w), 64'd0);
    check("mul_done_end", 64'(bus.done), 64'd0);
    check("mul_busy_end", 64'(bus.busy), 64'd0);
    issue(2'b01, 32'hFFFF_FFF9, 32'd2);
    wait_done(n);
    check("div_lat", 64'(n), 64'd33);
    check("div_lo", 64'(bus.lo_out), 64'hFFFF_FFFD);
    check("div_hi", 64'(bus.hi_out), 64'hFFFF_FFFF);
    issue(2'b10, 32'd100, 32'd7);
    wait_done(n);
    check("divm_lat", 64'(n), 64'd33);
    check("divm_lo", 64'(bus.lo_out), 64'd14);
    check("divm_hi", 64'(bus.hi_out), 64'd2);
    issue(2'b01, 32'd5, 32'd0);
    wait_done(n);
    check("dz_lat", 64'(n), 64'd0);
    check("dz_flag", 64'(bus.div_zero), 64'd1);
    check("dz_hiw", 64'(bus.hi_w), 64'd0);
    check("dz_low", 64'(bus.lo_w), 64'd0);
    check("dz_hi", 64'(bus.hi_out), 64'd2);
    check("dz_lo", 64'(bus.lo_out), 64'd14);
    @(negedge clk);
    check("dz_flag_end", 64'(bus.div_zero), 64'd0);
    issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    check("ovf_lo", 64'(bus.lo_out), 64'h8000_0000);
    check("ovf_hi", 64'(bus.hi_out), 64'd0);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_done(n);
    check("minmul_hi", 64'(bus.hi_out), 64'h4000_0000);
    check("minmul_lo", 64'(bus.lo_out), 64'd0);
    issue(2'b11, 32'd1, 32'd1);
    @(negedge clk);
    check("rsv_busy", 64'(bus.busy), 64'd0);
    check("rsv_done", 64'(bus.done), 64'd0);
    issue(2'b00, 32'd7, 32'hFFFF_FFFD);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a_in  = 32'd100;
    bus.b_in  = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n);
    check("busy_start_hi", 64'(bus.hi_out), 64'hFFFF_FFFF);
    check("busy_start_lo", 64'(bus.lo_out), 64'hFFFF_FFEB);
    issue(2'b10, 32'd100, 32'd7);
    wait_done(n);
    check("b2b_lat", 64'(n), 64'd33);
    check("b2b_lo", 64'(bus.lo_out), 64'd14);
    issue(2'b00, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd1 - 64'd1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.hi_w || bus.lo_w) cnt++;
    end
    check("abort_strobes", 64'(cnt), 64'd0);
    check("abort_lo", 64'(bus.lo_out), 64'd14);
    issue(2'b00, 32'd3, 32'd5);
    repeat (19) @(negedge clk);
    #2 reset_in = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_hi", 64'(bus.hi_out), 64'd0);
    check("arst_lo", 64'(bus.lo_out), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
